// File: rtl/image_refill_irq_ctrl_if.sv
// Host-facing handshakes of the refill controller: status-read port, refill
// data stream in, and pixel stream out toward the per-channel FIFOs.
interface image_refill_irq_ctrl_if #(
  parameter int DATA_W = 128,
  parameter int CH_W   = 2,
  parameter int LEN_W  = 9
);
  logic              rd_req;
  logic              rd_ack;
  logic              rd_hit;
  logic [CH_W-1:0]   rd_ch;
  logic [LEN_W-1:0]  rd_len;

  logic              s_valid;
  logic              s_last;
  logic [DATA_W-1:0] s_data;
  logic [CH_W-1:0]   s_ch;
  logic              s_ready;

  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic [CH_W-1:0]   m_ch;
  logic              m_ready;

  modport slave (
    input  rd_req, s_valid, s_last, s_data, s_ch, m_ready,
    output rd_ack, rd_hit, rd_ch, rd_len, s_ready, m_valid, m_data, m_ch
  );

  modport master (
    output rd_req, s_valid, s_last, s_data, s_ch, m_ready,
    input  rd_ack, rd_hit, rd_ch, rd_len, s_ready, m_valid, m_data, m_ch
  );
endinterface

// File: rtl/image_refill_irq_ctrl.sv
// Per-channel refill request tracker: raises irq when a FIFO drops below its
// watermark, hands out bursts on status reads and forwards the refill beats.
module image_refill_irq_ctrl #(
  parameter  int NUM_CH    = 4,
  parameter  int DATA_W    = 128,
  parameter  int DEPTH     = 4096,
  parameter  int MAX_BURST = 256,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int LVL_W     = $clog2(DEPTH) + 1,
  localparam int LEN_W     = $clog2(MAX_BURST) + 1
) (
  input  logic                    s_axi_aclk,
  input  logic                    reset,
  input  logic                    cfg_en,
  input  logic [NUM_CH*LVL_W-1:0] cfg_watermark,
  input  logic [NUM_CH*LVL_W-1:0] fifo_level,
  output logic                    irq,
  output logic                    err_pulse,
  image_refill_irq_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2
  } ch_state_e;

  ch_state_e        state_q [NUM_CH];
  ch_state_e        state_d [NUM_CH];
  logic [LEN_W-1:0] len_q   [NUM_CH];
  logic [LEN_W-1:0] len_d   [NUM_CH];
  logic [LEN_W-1:0] cnt_q   [NUM_CH];
  logic [LEN_W-1:0] cnt_d   [NUM_CH];

  logic [LEN_W-1:0] refill_len [NUM_CH];
  logic             refill_ok  [NUM_CH];
  logic             last_beat  [NUM_CH];

  logic              irq_q, irq_d;
  logic              err_q, err_d;
  logic              rd_ack_q, rd_ack_d;
  logic              rd_hit_q, rd_hit_d;
  logic [CH_W-1:0]   rd_ch_q, rd_ch_d;
  logic [LEN_W-1:0]  rd_len_q, rd_len_d;
  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [CH_W-1:0]   m_ch_q, m_ch_d;

  logic              s_ready;
  logic              accept;
  logic              fwd;
  logic              proto_err;
  logic              rd_found;
  logic [CH_W-1:0]   rd_sel;
  logic [LEN_W-1:0]  rd_sel_len;

  // Refill size is the free space in the FIFO, capped at one maximum burst;
  // a full (or over-reported) FIFO yields zero and never requests.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [31:0] level32;
    logic [31:0] wm32;
    logic [31:0] room32;

    assign level32 = 32'(fifo_level[gi*LVL_W +: LVL_W]);
    assign wm32    = 32'(cfg_watermark[gi*LVL_W +: LVL_W]);
    assign room32  = (level32 >= 32'(DEPTH)) ? 32'd0 : (32'(DEPTH) - level32);

    assign refill_len[gi] = (room32 > 32'(MAX_BURST)) ? LEN_W'(MAX_BURST) : LEN_W'(room32);
    assign refill_ok[gi]  = (level32 < wm32) && (room32 != 32'd0);
    assign last_beat[gi]  = (cnt_q[gi] == (len_q[gi] - LEN_W'(1)));
  end

  assign s_ready = !m_valid_q || bus.m_ready;
  assign accept  = bus.s_valid && s_ready;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    rd_found   = 1'b0;
    rd_sel     = '0;
    rd_sel_len = '0;
    fwd        = 1'b0;
    proto_err  = 1'b0;

    // Descending scan so the lowest-index requester is the one left selected.
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (state_q[c] == ST_REQ) begin
        rd_found   = 1'b1;
        rd_sel     = CH_W'(c);
        rd_sel_len = len_q[c];
      end
    end

    for (int c = 0; c < NUM_CH; c++) begin
      unique case (state_q[c])
        ST_IDLE: begin
          if (cfg_en && refill_ok[c]) begin
            state_d[c] = ST_REQ;
            len_d[c]   = refill_len[c];
            cnt_d[c]   = '0;
          end
        end
        ST_REQ: begin
          if (bus.rd_req && (rd_sel == CH_W'(c))) begin
            state_d[c] = ST_XFER;
          end
        end
        ST_XFER: begin
          if (accept && (bus.s_ch == CH_W'(c))) begin
            fwd = 1'b1;
            // An early or missing s_last still closes the burst, but is flagged.
            if (last_beat[c] || bus.s_last) begin
              state_d[c] = ST_IDLE;
              cnt_d[c]   = '0;
            end else begin
              cnt_d[c] = cnt_q[c] + LEN_W'(1);
            end
            if (last_beat[c] != bus.s_last) begin
              proto_err = 1'b1;
            end
          end
        end
        default: state_d[c] = ST_IDLE;
      endcase
    end

    if (accept && !fwd) begin
      proto_err = 1'b1;
    end

    rd_ack_d = bus.rd_req;
    rd_hit_d = bus.rd_req && rd_found;
    rd_ch_d  = rd_hit_d ? rd_sel : '0;
    rd_len_d = rd_hit_d ? rd_sel_len : '0;

    irq_d = rd_found;
    err_d = proto_err;

    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_ch_d    = m_ch_q;
    if (fwd) begin
      m_valid_d = 1'b1;
      m_data_d  = bus.s_data;
      m_ch_d    = bus.s_ch;
    end else if (bus.m_ready) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        state_q[c] <= ST_IDLE;
        len_q[c]   <= '0;
        cnt_q[c]   <= '0;
      end
      irq_q     <= 1'b0;
      err_q     <= 1'b0;
      rd_ack_q  <= 1'b0;
      rd_hit_q  <= 1'b0;
      rd_ch_q   <= '0;
      rd_len_q  <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_ch_q    <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      irq_q     <= irq_d;
      err_q     <= err_d;
      rd_ack_q  <= rd_ack_d;
      rd_hit_q  <= rd_hit_d;
      rd_ch_q   <= rd_ch_d;
      rd_len_q  <= rd_len_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_ch_q    <= m_ch_d;
    end
  end

  assign irq         = irq_q;
  assign err_pulse   = err_q;
  assign bus.rd_ack  = rd_ack_q;
  assign bus.rd_hit  = rd_hit_q;
  assign bus.rd_ch   = rd_ch_q;
  assign bus.rd_len  = rd_len_q;
  assign bus.s_ready = s_ready;
  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;
  assign bus.m_ch    = m_ch_q;

endmodule

// File: doc/image_refill_irq_ctrl.md
IMAGE_REFILL_IRQ_CTRL -- requirements
Module: image_refill_irq_ctrl

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, meaning number of image channels (1..8); CH_W = max(1, clog2(NUM_CH)).
REQ-002 SHALL have parameter DATA_W, default 128, meaning pixel data beat width.
REQ-003 SHALL have parameter DEPTH, default 4096, meaning downstream FIFO depth in beats; LVL_W = clog2(DEPTH)+1.
REQ-004 SHALL have parameter MAX_BURST, default 256, meaning maximum beats per refill request; LEN_W = clog2(MAX_BURST)+1.
REQ-005 Ports: s_axi_aclk  in  1  sole clock; all logic on rising edge.
REQ-006 Ports: reset  in  1  synchronous, active-high reset.
REQ-007 Ports: cfg_en  in  1  enables new refill requests.
REQ-008 Ports: cfg_watermark  in  NUM_CH*LVL_W  per-channel low watermark, channel c at [c*LVL_W +: LVL_W].
REQ-009 Ports: fifo_level  in  NUM_CH*LVL_W  per-channel downstream FIFO occupancy, same packing.
REQ-010 Ports: rd_req  in  1  host status-read strobe (one cycle).
REQ-011 Ports: rd_ack / rd_hit / rd_ch / rd_len  out  1 / 1 / CH_W / LEN_W  status-read response.
REQ-012 Ports: s_valid, s_last in 1; s_data in DATA_W; s_ch in CH_W; s_ready out 1: host refill data stream.
REQ-013 Ports: m_valid out 1; m_data out DATA_W; m_ch out CH_W; m_ready in 1: stream to pixel FIFOs.
REQ-014 Ports: irq  out  1  level interrupt; err_pulse  out  1  one-cycle protocol-error flag.

Function
REQ-015 Each channel SHALL run an FSM with states IDLE, REQ, XFER.
REQ-016 IDLE->REQ SHALL occur when cfg_en=1 and fifo_level[c] < cfg_watermark[c]; on that edge len[c] = min(MAX_BURST, DEPTH - fifo_level[c]) is latched.
REQ-017 If computed len is 0, channel SHALL remain IDLE.
REQ-018 irq SHALL be registered: high the cycle after any channel is in REQ, low the cycle after none are.
REQ-019 rd_req SHALL produce rd_ack=1 exactly one cycle later; rd_hit=1, rd_ch=lowest-index channel in REQ, rd_len=its len; that channel moves REQ->XFER on the same edge as rd_ack.
REQ-020 If no channel is in REQ at rd_req, response SHALL be rd_hit=0, rd_ch=0, rd_len=0, no state change.
REQ-021 A beat SHALL be accepted when s_valid && s_ready; s_ready = !m_valid || m_ready (single output register, no bubble under continuous m_ready).
REQ-022 An accepted beat for a channel in XFER SHALL appear on m_valid/m_data/m_ch the next cycle and increment that channel's beat counter.
REQ-023 When the beat with count == len-1 is accepted, the channel SHALL return to IDLE; s_last SHALL be 1 on exactly that beat.
REQ-024 s_last=1 before count==len-1, or s_last=0 on count==len-1: channel SHALL still return to IDLE, beat forwarded, err_pulse=1 for one cycle.
REQ-025 A beat whose s_ch is not in XFER, or s_ch >= NUM_CH, SHALL be accepted, dropped (not forwarded), and raise err_pulse.
REQ-026 m_valid SHALL hold with m_data/m_ch stable until m_ready.
REQ-027 cfg_en=0 SHALL block IDLE->REQ only; REQ and XFER channels proceed normally.
REQ-028 A channel finishing XFER SHALL NOT re-request on the same edge; re-evaluation starts the following cycle.
REQ-029 rd_req while a previous rd_ack is pending SHALL be serviced in order, one response per request, back-to-back allowed.

Reset
REQ-030 On reset: all channels IDLE, counters and len 0, irq=0, rd_ack=0, rd_hit=0, rd_ch=0, rd_len=0, m_valid=0, m_data=0, m_ch=0, err_pulse=0.
REQ-031 Reset mid-XFER SHALL abandon the burst with no output beat and no err_pulse.

Verification
REQ-032 NUM_CH=4, watermark[2]=1024, level[2]=1000, cfg_en=1 -> irq=1; rd_req -> rd_hit=1, rd_ch=2, rd_len=256; irq=0 after.
REQ-033 After REQ-032, 256 beats on ch2 with s_last on 256th, m_ready=1 -> 256 m_valid beats in order, err_pulse never set, ch2 IDLE.
REQ-034 level[0]=4000, watermark[0]=4090 -> rd_len=96; channels 1 and 3 also requesting -> three rd_req return ch 1? no: 0, then 1, then 3.
REQ-035 s_last on beat 10 of len 96 -> err_pulse once, channel IDLE, 10 beats forwarded; beat to IDLE ch1 -> dropped, err_pulse.
REQ-036 m_ready toggled 50% random during burst -> no lost or duplicated beats; reset asserted at beat 40 -> all outputs at reset values next cycle.
REQ-037 rd_req with no channel in REQ -> rd_ack=1, rd_hit=0, rd_len=0; cfg_en=0 with level below watermark -> irq stays 0.
